// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with frame sync, selectable bit order
// and a valid/ready output holder. Define SIPO_DESER_PARITY_EN for a trailing even-parity bit.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic             data_i,
  input  logic             sync_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
`ifdef SIPO_DESER_PARITY_EN
  ,
  output logic             parity_err_o
`endif
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = (FRAME > 2) ? $clog2(FRAME) : 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {s[WIDTH-2:0], b};
    end else begin
      r = {b, s[WIDTH-1:1]};
    end
    return r;
  endfunction

`ifdef SIPO_DESER_PARITY_EN
  // Even parity: data bits plus parity bit must contain an even number of ones.
  function automatic logic even_parity_err(input logic [WIDTH-1:0] w, input logic p);
    return (^w) ^ p;
  endfunction
`endif

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  hold_state_e      hold_q, hold_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             complete_s;
  logic [WIDTH-1:0] word_s;
`ifdef SIPO_DESER_PARITY_EN
  logic             perr_s;
  logic             perr_q, perr_d;
`endif

  // Bit acceptance: shift, count, resync and detect word completion.
  always_comb begin
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    complete_s = 1'b0;
    word_s     = shift_in(sreg_q, data_i);
`ifdef SIPO_DESER_PARITY_EN
    perr_s     = 1'b0;
`endif
    if (valid_i) begin
      if (sync_i) begin
        // Sync beats completion; the stale partial word is flushed.
        sreg_d = shift_in({WIDTH{1'b0}}, data_i);
        cnt_d  = CNT_ONE;
      end else if (cnt_q == CNT_LAST) begin
        complete_s = 1'b1;
        cnt_d      = CNT_ZERO;
`ifdef SIPO_DESER_PARITY_EN
        word_s     = sreg_q;
        perr_s     = even_parity_err(sreg_q, data_i);
        sreg_d     = sreg_q;
`else
        sreg_d     = shift_in(sreg_q, data_i);
`endif
      end else begin
        sreg_d = shift_in(sreg_q, data_i);
        cnt_d  = cnt_q + CNT_ONE;
      end
    end else begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
    end
  end

  // Output holder: load, transfer, or drop a completed word under backpressure.
  always_comb begin
    hold_d = hold_q;
    data_d = data_q;
    ovf_d  = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    perr_d = perr_q;
`endif
    case (hold_q)
      HOLD_EMPTY: begin
        if (complete_s) begin
          hold_d = HOLD_FULL;
          data_d = word_s;
`ifdef SIPO_DESER_PARITY_EN
          perr_d = perr_s;
`endif
        end else begin
          hold_d = HOLD_EMPTY;
        end
      end
      HOLD_FULL: begin
        if (complete_s && ready_i) begin
          hold_d = HOLD_FULL;
          data_d = word_s;
`ifdef SIPO_DESER_PARITY_EN
          perr_d = perr_s;
`endif
        end else if (complete_s) begin
          hold_d = HOLD_FULL;
          ovf_d  = 1'b1;
        end else if (ready_i) begin
          hold_d = HOLD_EMPTY;
        end else begin
          hold_d = HOLD_FULL;
        end
      end
      default: begin
        hold_d = HOLD_EMPTY;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sreg_q <= {WIDTH{1'b0}};
      cnt_q  <= CNT_ZERO;
      hold_q <= HOLD_EMPTY;
      data_q <= {WIDTH{1'b0}};
      ovf_q  <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
`ifdef SIPO_DESER_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign valid_o    = (hold_q == HOLD_FULL);
  assign data_o     = data_q;
  assign overflow_o = ovf_q;
`ifdef SIPO_DESER_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Randomised and directed bench for sipo_deser: one MSB-first and one LSB-first instance
// share stimulus and are checked every cycle against a queue-based frame model.
module tb_sipo_deser;
  localparam int W = 8;
`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n    = 1'b0;
  logic         valid_in = 1'b0;
  logic         data_in  = 1'b0;
  logic         sync_in  = 1'b0;
  logic         ready_in = 1'b0;
  logic         valid0, valid1, ovf0, ovf1;
  logic [W-1:0] data0, data1;
`ifdef SIPO_DESER_PARITY_EN
  logic         perr0, perr1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_in), .data_i(data_in),
    .sync_i(sync_in), .ready_i(ready_in), .valid_o(valid0), .data_o(data0),
    .overflow_o(ovf0)
`ifdef SIPO_DESER_PARITY_EN
    , .parity_err_o(perr0)
`endif
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_in), .data_i(data_in),
    .sync_i(sync_in), .ready_i(ready_in), .valid_o(valid1), .data_o(data1),
    .overflow_o(ovf1)
`ifdef SIPO_DESER_PARITY_EN
    , .parity_err_o(perr1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 is the MSB-first instance, 1 the LSB-first instance.
  bit           mq[$];
  logic [W-1:0] m_data[2];
  bit           m_valid[2];
  bit           m_ovf[2];
  bit           m_perr[2];
  bit           m_complete;
  bit           m_pe;
  bit           m_xfer;
  logic [W-1:0] m_word[2];

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_data[m] = '0; m_valid[m] = 1'b0; m_ovf[m] = 1'b0; m_perr[m] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      for (int m = 0; m < 2; m++) begin
        m_data[m] = '0; m_valid[m] = 1'b0; m_ovf[m] = 1'b0; m_perr[m] = 1'b0;
      end
    end else begin
      m_complete = 1'b0;
      if (valid_in) begin
        if (sync_in) begin
          mq.delete();
          mq.push_back(data_in);
        end else begin
          mq.push_back(data_in);
          if (mq.size() == FRAME) begin
            m_complete = 1'b1;
            m_word[0] = '0;
            m_word[1] = '0;
            for (int i = 0; i < W; i++) begin
              m_word[0][W-1-i] = mq[i];
              m_word[1][i]     = mq[i];
            end
            m_pe = 1'b0;
            for (int i = 0; i < FRAME; i++) m_pe = m_pe ^ mq[i];
            mq.delete();
          end
        end
      end
      for (int m = 0; m < 2; m++) begin
        m_xfer   = m_valid[m] && ready_in;
        m_ovf[m] = 1'b0;
        if (m_complete) begin
          if (m_valid[m] && !m_xfer) begin
            m_ovf[m] = 1'b1;
          end else begin
            m_data[m]  = m_word[m];
            m_valid[m] = 1'b1;
            m_perr[m]  = m_pe;
          end
        end else if (m_xfer) begin
          m_valid[m] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("msb valid_o", valid0, m_valid[0]);
      check("msb data_o", data0, m_data[0]);
      check("msb overflow_o", ovf0, m_ovf[0]);
      check("lsb valid_o", valid1, m_valid[1]);
      check("lsb data_o", data1, m_data[1]);
      check("lsb overflow_o", ovf1, m_ovf[1]);
`ifdef SIPO_DESER_PARITY_EN
      if (m_valid[0]) check("msb parity_err_o", perr0, m_perr[0]);
      if (m_valid[1]) check("lsb parity_err_o", perr1, m_perr[1]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input bit b, input bit s, input int gap);
    valid_in = 1'b1; data_in = b; sync_in = s;
    tick();
    valid_in = 1'b0; data_in = 1'b0; sync_in = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends w with its MSB on the wire first, plus a correct parity bit when enabled.
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit sync_first);
    for (int i = 0; i < W; i++) send_bit(w[W-1-i], sync_first && (i == 0), (i == FRAME-1) ? 0 : gap);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(^w, 1'b0, 0);
`endif
  endtask

  task automatic flush();
    ready_in = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    check_en = 1'b1;
    check("reset valid_o", valid0, 1'b0);
    check("reset data_o", data0, 8'h00);
    check("reset overflow_o", ovf0, 1'b0);
    rst_n = 1'b1;
    ready_in = 1'b1;
    tick();

    // Basic MSB-first word, consecutive bits.
    send_word(8'hA5, 0, 1'b0);
    check("t1 msb data", data0, 8'hA5);
    check("t1 msb valid", valid0, 1'b1);
    check("t1 model data", m_data[0], 8'hA5);
    check("t1 ovf", ovf0, 1'b0);
    tick();
    check("t1 valid drops", valid0, 1'b0);

    // Gapped bits; LSB-first instance.
    send_word(8'hA5, 2, 1'b0);
    check("t2 lsb data a5", data1, 8'hA5);
    flush();
    send_word(8'hC0, 0, 1'b0);
    check("t2 lsb data 03", data1, 8'h03);
    check("t2 msb data c0", data0, 8'hC0);
    check("t2 model lsb", m_data[1], 8'h03);
    flush();

    // Backpressure and overflow.
    ready_in = 1'b0;
    send_word(8'h3C, 0, 1'b0);
    check("t3 first held", data0, 8'h3C);
    send_word(8'hC3, 0, 1'b0);
    check("t3 ovf pulse", ovf0, 1'b1);
    check("t3 data kept", data0, 8'h3C);
    check("t3 lsb data kept", data1, 8'h3C);
    tick();
    check("t3 ovf one cycle", ovf0, 1'b0);
    ready_in = 1'b1;
    tick();
    check("t3 valid drops", valid0, 1'b0);
    send_word(8'h5A, 0, 1'b0);
    check("t3 next word", data0, 8'h5A);
    check("t3 next ovf", ovf0, 1'b0);
    flush();

    // Partial word abandoned by sync.
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
    check("t4 no spurious", valid0, 1'b0);
    send_word(8'h81, 0, 1'b1);
    check("t4 sync word", data0, 8'h81);
    check("t4 sync word lsb", data1, 8'h81);
    check("t4 no ovf", ovf0, 1'b0);
    flush();

    // Completion coinciding with transfer.
    ready_in = 1'b0;
    send_word(8'h99, 0, 1'b0);
    for (int i = 0; i < W-1; i++) send_bit(8'h66 >> (W-1-i), 1'b0, 0);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(1'b0, 1'b0, 0);
    ready_in = 1'b1;
    send_bit(1'b0, 1'b0, 0);
`else
    ready_in = 1'b1;
    send_bit(1'b0, 1'b0, 0);
`endif
    check("t5 valid stays", valid0, 1'b1);
    check("t5 new word", data0, 8'h66);
    check("t5 no ovf", ovf0, 1'b0);
    flush();

    // Reset mid-frame.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6 reset valid", valid0, 1'b0);
    check("t6 reset data", data0, 8'h00);
    for (int i = 0; i < FRAME-1; i++) send_bit(1'b1 ^ ((i == W) ? 1'b1 : 1'b0), 1'b0, 0);
    check("t6 not early", valid0, 1'b0);
    send_bit((FRAME == W) ? 1'b1 : 1'b0, 1'b0, 0);
    check("t6 ff word", data0, 8'hFF);
    check("t6 ff valid", valid0, 1'b1);
    flush();

`ifdef SIPO_DESER_PARITY_EN
    for (int i = 0; i < W; i++) send_bit(8'hA5 >> (W-1-i), 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    check("t7 bad parity", perr0, 1'b1);
    check("t7 bad parity data", data0, 8'hA5);
    flush();
    for (int i = 0; i < W; i++) send_bit(8'hA5 >> (W-1-i), 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    check("t7 good parity", perr0, 1'b0);
    flush();
`endif

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      valid_in = ($urandom_range(0, 99) < 70);
      data_in  = 1'($urandom_range(0, 1));
      sync_in  = valid_in && ($urandom_range(0, 99) < 3);
      ready_in = ($urandom_range(0, 99) < 50);
      rst_n    = !($urandom_range(0, 999) < 4);
      tick();
    end
    rst_n = 1'b1;
    valid_in = 1'b0;
    sync_in = 1'b0;
    tick();
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserialiser. Successor to the fixed 4-bit SIPO.
- Serial input is qualified per bit by a valid strobe. A frame-sync input realigns word boundaries.
- Bit order is selectable.
- Completed words are held in an output register with a valid/ready handshake. Words dropped under backpressure are flagged.
- Sits between a serial front end (SPI/UART-style bit recovery) and a parallel word consumer.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = first received bit lands in data_o[WIDTH-1]; 0 = first bit lands in data_o[0].

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_n_i  input  1  synchronous, active-low reset.
- valid_i  input  1  data_i carries a bit this cycle.
- data_i  input  1  serial data bit.
- sync_i  input  1  start-of-frame; sampled only when valid_i=1.
- ready_i  input  1  consumer accepts data_o this cycle.
- valid_o  output  1  data_o holds an unconsumed word.
- data_o  output  WIDTH  parallel word.
- overflow_o  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - Shift register, bit counter, data_o, valid_o and overflow_o all clear to 0.
  - Any partial word or held word is discarded.
  - Reset takes priority over all other inputs.
- Bit counter:
  - Width is $clog2(WIDTH).
  - Increments only on accepted bits (valid_i=1).
  - Wraps to 0 after bit WIDTH-1 is accepted.
  - valid_i=0 cycles freeze the shift register and counter (gaps allowed anywhere).
- Shift direction:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], data_i}.
  - MSB_FIRST=0: sreg <= {data_i, sreg[WIDTH-1:1]}.
- Sync:
  - valid_i=1 with sync_i=1 forces the bit to be bit 0 of a new word.
  - Counter restarts at 1 after that bit; any partial word is discarded, with no overflow.
  - sync_i with valid_i=0 is ignored.
- Word completion:
  - Occurs on the cycle the WIDTH-th bit is accepted.
  - The assembled word (including that bit) is written to data_o at that clock edge.
  - valid_o=1 from the next cycle. Latency is one clock from last-bit acceptance to valid_o.
- Output handshake:
  - Transfer happens when valid_o=1 and ready_i=1. valid_o then deasserts next cycle unless a new word completes in the same cycle.
  - data_o is stable while valid_o=1 and ready_i=0.
  - ready_i while valid_o=0 has no effect.
- Output holder states:
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on transfer with no completion.
  - FULL -> FULL on completion together with transfer: new word loaded, no bubble, no overflow.
  - FULL with completion and no transfer: new word dropped, data_o keeps the old word, overflow_o=1 for exactly one cycle (next cycle). The counter still wraps, so the next word stays aligned.
- Same cycle sync + completion (WIDTH=1-bit frames are illegal, so this is only possible via resync): sync wins, no completion.
- Reset mid-frame or with valid_o=1: all state is lost; the next word needs WIDTH fresh bits.

Optional Feature:
- Macro: SIPO_DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH+1 accepted bits; the final bit is even parity over the WIDTH data bits.
  - The counter runs 0..WIDTH.
  - Completion occurs on the parity bit.
  - Extra output port parity_err_o (1 bit, reset 0) is updated with data_o on every load and is valid while valid_o=1.
  - A word with bad parity is still delivered.
- Undefined: frame is WIDTH bits and parity_err_o does not exist.

Test Plan:
- Reset then WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, ready_i=1 -> data_o=0xA5 with valid_o=1 for one cycle, asserted the cycle after the 8th bit; overflow_o stays 0.
- MSB_FIRST=0, same bit sequence with 2-cycle valid_i gaps between bits -> data_o=0xA5 bit-reversed = 0xA5; then sequence 1,1,0,0,0,0,0,0 -> data_o=0x03.
- ready_i=0, send two full words 0x3C then 0xC3 -> data_o stays 0x3C, overflow_o pulses once after the 8th bit of the second word. Then ready_i=1 -> valid_o drops and next word 0x5A arrives clean.
- Send 5 bits, then valid_i=1 with sync_i=1 starting word 0x81 -> data_o=0x81, no spurious word, no overflow.
- Completion on the same cycle as ready_i=1 with valid_o=1 -> valid_o stays high, data_o updates to the new word, overflow_o=0.
- Assert rst_n_i=0 after 4 bits, release, send 0xFF -> data_o=0xFF after exactly 8 post-reset bits. With SIPO_DESER_PARITY_EN, 0xA5 with parity 1 -> parity_err_o=1; with parity 0 -> parity_err_o=0.
